// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if
//
// Bus bundle between the instruction fetch stage, program ROM and the
// decoder.
//
//   romAdd       [15:0] ROM half-word address {instruction address, half}
//   romRead             ROM read strobe; data returns one cycle later
//   romData      [15:0] ROM read data
//   instrWord    [31:0] head instruction {half 1, half 0}
//   instrPc      [14:0] instruction address of the head entry
//   instrValid          head entry present
//   instrReady          decoder consumes the head entry this cycle
//   branchTake          redirect request (single-cycle pulse)
//   branchTarget [14:0] redirect instruction address
//
// master : the fetch stage (drives ROM request and decoder-facing outputs)
// slave  : the environment (ROM + decoder + branch unit)
// ----------------------------------------------------------------------------
interface instr_fetch_if;
  logic [15:0] romAdd;
  logic        romRead;
  logic [15:0] romData;
  logic [31:0] instrWord;
  logic [14:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        branchTake;
  logic [14:0] branchTarget;

  modport master (
    output romAdd,
    output romRead,
    input  romData,
    output instrWord,
    output instrPc,
    output instrValid,
    input  instrReady,
    input  branchTake,
    input  branchTarget
  );

  modport slave (
    input  romAdd,
    input  romRead,
    output romData,
    input  instrWord,
    input  instrPc,
    input  instrValid,
    output instrReady,
    output branchTake,
    output branchTarget
  );
endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage feeding the decoder. Each 32-bit instruction is
// read from program ROM as two 16-bit halves (half 0 then half 1), assembled
// and pushed into a small prefetch queue. The queue head is presented to the
// decoder over a valid/ready handshake. A branch redirect flushes the queue,
// drops any half-fetched instruction and restarts fetch at the target.
//
// Parameters
//   DEPTH     prefetch queue depth in instructions (designed for 2)
//   RESET_PC  instruction address fetched after reset
//
// Ports
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous active-high reset
//   bus   instr_fetch_if.master: ROM request/data, decoder handshake,
//         branch redirect
//
// Timing from the first cycle after reset/redirect (cycle 0): low half
// issued in cycle 0, high half in cycle 1, queue push in cycle 2, the
// instruction is visible on instrValid/instrWord/instrPc in cycle 3.
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic          CLK,
  input  logic          RST,
  instr_fetch_if.master bus
);

  localparam logic [0:0] ST_LO = 1'b0;  // next read is half 0 (gated by room)
  localparam logic [0:0] ST_HI = 1'b1;  // next read is half 1 (unconditional)

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] word;
    logic [14:0] pc;
  } entry_t;

  // Fetch sequencer state
  logic [0:0]    state_q, state_d;
  logic [14:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   low_q, low_d;         // half 0 waiting for its partner
  logic          pend_q, pend_d;       // assembled instruction lands this cycle
  logic [14:0]   pend_pc_q, pend_pc_d;
  logic [15:0]   rom_add_q;            // last address driven, held when idle

  // Prefetch queue, head at index 0
  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  // Registered decoder-facing outputs
  logic [31:0]   word_q;
  logic [14:0]   pc_q;
  logic          valid_q;

  logic          issue;
  logic [15:0]   issue_addr;
  logic          room;
  logic          push;
  logic          pop;
  logic [CW-1:0] wr_idx;
  entry_t        new_ent;

  // Room counts the instruction already in flight to the queue but not a
  // same-cycle pop, so a new fetch never starts until space is certain.
  assign room = (int'(count_q) + int'(pend_q)) < DEPTH;

  // --------------------------------------------------------------------------
  // Fetch sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    low_d      = low_q;
    pend_d     = 1'b0;          // a pending write lives for exactly one cycle
    pend_pc_d  = pend_pc_q;
    issue      = 1'b0;
    issue_addr = rom_add_q;

    case (state_q)
      ST_LO: begin
        if (room) begin
          issue      = 1'b1;
          issue_addr = {fetch_pc_q, 1'b0};
          state_d    = ST_HI;
        end
      end
      ST_HI: begin
        // romData now carries half 0 requested in the previous cycle.
        issue      = 1'b1;
        issue_addr = {fetch_pc_q, 1'b1};
        low_d      = bus.romData;
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 15'd1;  // wraps 7FFF -> 0000
        state_d    = ST_LO;
      end
      default: begin
        state_d = ST_LO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Prefetch queue
  // --------------------------------------------------------------------------
  assign push    = pend_q;
  assign pop     = valid_q & bus.instrReady;
  // With a simultaneous pop the entries shift down first, so the new entry
  // goes one slot lower; this keeps program order.
  assign wr_idx  = count_q - CW'(pop);
  assign new_ent = {bus.romData, low_q, pend_pc_q};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_d[i] = ent_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          ent_d[i] = new_ent;
        end
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // --------------------------------------------------------------------------
  // State registers. Redirect outranks every other update, including a
  // same-cycle pop (treated as consumed), push and high-half issue.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_LO;
      fetch_pc_q <= RESET_PC;
      low_q      <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      rom_add_q  <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      pc_q       <= '0;
    end else if (bus.branchTake) begin
      state_q    <= ST_LO;
      fetch_pc_q <= bus.branchTarget;
      pend_q     <= 1'b0;
      rom_add_q  <= issue_addr;
      count_q    <= '0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      low_q      <= low_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      rom_add_q  <= issue_addr;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      word_q     <= (count_d != '0) ? ent_d[0].word : '0;
      pc_q       <= (count_d != '0) ? ent_d[0].pc   : '0;
    end
  end

  // Queue storage carries no reset; count_q alone defines occupancy.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The ROM request is combinational from the sequencer state so a
  // read goes out in the very first cycle after reset/redirect; it is forced
  // to zero while reset is held.
  // --------------------------------------------------------------------------
  assign bus.romRead    = issue & ~RST;
  assign bus.romAdd     = RST ? 16'h0000 : issue_addr;
  assign bus.instrWord  = word_q;
  assign bus.instrPc    = pc_q;
  assign bus.instrValid = valid_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the control/decode unit. It reads 32-bit instruction words as two consecutive 16-bit halves from program ROM, assembles them, and buffers up to two complete instructions in a prefetch queue. It presents them to the decoder over a valid/ready handshake. Control-flow redirects (jumps/branches) flush the queue and restart fetch at a new instruction address.

## Interface
Parameters:
- DEPTH, 2, prefetch queue depth in instructions; only 2 is supported.
- RESET_PC, 15'h0000, instruction address fetched after reset.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- romAdd  out  16  ROM half-word address = {fetchPc[14:0], half}; half 0 = low word, half 1 = word2.
- romRead  out  1  ROM read strobe; romData is valid in the cycle after romRead=1.
- romData  in  16  ROM read data, one-cycle latency.
- instrWord  out  32  head instruction: [31:16] = word2 (half 1), [15:0] = opcode/operand word (half 0); 0 when instrValid=0.
- instrPc  out  15  instruction address of head entry; 0 when instrValid=0.
- instrValid  out  1  head entry present.
- instrReady  in  1  decoder accepts head this cycle (pop when instrValid & instrReady).
- branchTake  in  1  redirect request, one-cycle pulse.
- branchTarget  in  15  new instruction address, sampled with branchTake.

## Operation
- State machine: LO, HI.
  - LO: if count + pendingWrite < 2, issue romRead=1, romAdd={fetchPc,0}, go HI. Otherwise romRead=0 and stay LO. The room check ignores a same-cycle pop (conservative).
  - HI: always issue romRead=1, romAdd={fetchPc,1}. Latch romData (low half) into lowReg. Set pendingWrite. fetchPc <= fetchPc+1. Go LO.
  - Write: in the cycle with pendingWrite=1, push {romData, lowReg} with its PC into the queue and clear pendingWrite.
- Queue: 2 entries, count 0..2. A push and a pop in the same cycle leave count unchanged and preserve order. A push when count=2 cannot occur; the LO room check guarantees this.
- fetchPc wraps 15'h7FFF -> 15'h0000. The entry at 7FFF carries instrPc=7FFF; the next entry carries 0000.
- Redirect (branchTake=1 at an edge):
  - Clear the queue.
  - Cancel pendingWrite and any half-fetched instruction.
  - fetchPc <= branchTarget; state <= LO.
  - Branch beats a simultaneous pop, push or HI issue; the popped entry is considered consumed.
- Reset: same effect as a redirect to RESET_PC, plus every output forced to 0.
- romRead=0 in any cycle where no half is issued; romAdd holds its last value then.

## Timing
- Reset values: romAdd=0, romRead=0, instrWord=0, instrPc=0, instrValid=0; state LO, count 0, pendingWrite 0.
- Cycle 0 = first cycle with RST low, or first cycle after a redirect edge.
  - Cycle 0: issue low half.
  - Cycle 1: issue high half.
  - Cycle 2: push.
  - Cycle 3: instrValid=1.
- Fetch-to-valid latency: 3 cycles. Sustained throughput: one instruction per 2 cycles.
- With instrReady=0, the queue fills with 2 entries. LO stalls until a pop frees space; issue resumes the cycle after the pop.
- instrWord, instrPc and instrValid are registered and change only at posedge.
- A redirect at the edge ending cycle b gives instrValid=0 in cycle b+1. The first target instruction is valid at b+4.

## Test plan
- Reset release, ROM[0..3]=1111,2222,3333,4444, instrReady=1 -> cycle 3: instrValid=1, instrWord=32'h2222_1111, instrPc=0. Cycle 5: instrWord=32'h4444_3333, instrPc=1.
- instrReady=0 for 10 cycles -> romRead stops after 2 instructions are queued (count=2). Raise instrReady -> PCs 0,1,2 delivered in order, none lost or duplicated.
- branchTake with branchTarget=15'h0100 while the queue is full and HI is in progress -> instrValid=0 next cycle, romAdd=16'h0200 issued next cycle, first valid instrPc=0x100 at b+4.
- branchTake coincident with instrValid&instrReady and a pending push -> no stale entry is ever presented after the redirect.
- Start at RESET_PC=15'h7FFF -> romAdd sequence FFFE, FFFF, 0000, 0001; instrPc 7FFF then 0000.
- RST asserted mid-fetch with the queue non-empty -> all outputs 0 next cycle. After release, fetch restarts at RESET_PC with cycle-3 latency.
